// File: rtl/fpga_robots_tm_arbiter.sv
// fpga_robots_tm_arbiter
//
// Shares the single tile map memory port between game play logic (port A)
// and the host/debug path (port B). At most one access is granted per clock.
// Ties are broken round-robin. Read data returns a fixed two cycles after the
// grant. An optional fill engine writes one value to every tile map address
// from 0 up to CLR_LAST. The fill engine is built only when the macro
// FPGA_ROBOTS_TMARB_CLEAR_EN is defined.
//
// Handshake: x_req is held with x_adr/x_wen/x_wrt stable until x_gnt is seen
// high at the end of a cycle. x_gnt is combinational. A request still high in
// the cycle after its grant is treated as a new access.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   a_* / b_*         requester ports: req, adr, wen, wrt in; gnt, rvl, rdt out
//   clr_stb, clr_val  fill start pulse and fill value
//   clr_busy          fill in progress
//   m_adr/m_wen/m_wrt registered memory command
//   m_red             memory read data, valid one cycle after m_adr
module fpga_robots_tm_arbiter #(
  parameter int TM_AW = 13,
  parameter int TM_DW = 8,
  parameter logic [TM_AW-1:0] CLR_LAST = 13'h1FFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_req,
  input  logic [TM_AW-1:0] a_adr,
  input  logic             a_wen,
  input  logic [TM_DW-1:0] a_wrt,
  output logic             a_gnt,
  output logic             a_rvl,
  output logic [TM_DW-1:0] a_rdt,
  input  logic             b_req,
  input  logic [TM_AW-1:0] b_adr,
  input  logic             b_wen,
  input  logic [TM_DW-1:0] b_wrt,
  output logic             b_gnt,
  output logic             b_rvl,
  output logic [TM_DW-1:0] b_rdt,
  input  logic             clr_stb,
  input  logic [TM_DW-1:0] clr_val,
  output logic             clr_busy,
  output logic [TM_AW-1:0] m_adr,
  output logic             m_wen,
  output logic [TM_DW-1:0] m_wrt,
  input  logic [TM_DW-1:0] m_red
);

  logic             fill_start;  // fill accepted this cycle
  logic             fill_act;    // fill issues a write this cycle
  logic [TM_AW-1:0] fill_cnt;
  logic [TM_DW-1:0] fill_val;

`ifdef FPGA_ROBOTS_TMARB_CLEAR_EN
  typedef enum logic {S_IDLE, S_FILL} fill_state_t;
  fill_state_t fill_state;

  assign fill_start = (fill_state == S_IDLE) && clr_stb;
  assign fill_act   = (fill_state == S_FILL);
  assign clr_busy   = fill_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_state <= S_IDLE;
      fill_cnt   <= '0;
      fill_val   <= '0;
    end else begin
      case (fill_state)
        S_IDLE: begin
          if (clr_stb) begin
            fill_state <= S_FILL;
            fill_cnt   <= '0;
            fill_val   <= clr_val;
          end
        end
        S_FILL: begin
          // Stop on the last address instead of wrapping the counter.
          if (fill_cnt == CLR_LAST) begin
            fill_state <= S_IDLE;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end
        default: fill_state <= S_IDLE;
      endcase
    end
  end
`else
  logic unused_clr;
  assign unused_clr = ^{clr_stb, clr_val};
  assign fill_start = 1'b0;
  assign fill_act   = 1'b0;
  assign fill_cnt   = '0;
  assign fill_val   = '0;
  assign clr_busy   = 1'b0;
`endif

  // last_b high means B received the most recent grant; A wins the next tie.
  logic last_b;
  logic arb_ok;

  // A fill starting this cycle takes the memory port, so nothing is granted.
  assign arb_ok = !clr_busy && !fill_start;
  assign a_gnt  = arb_ok && a_req && (!b_req || last_b);
  assign b_gnt  = arb_ok && b_req && (!a_req || !last_b);

  // Read tag: one entry follows each granted read to the cycle where m_red
  // holds its data.
  logic tag_vld;
  logic tag_b;
  logic [TM_DW-1:0] a_hold;
  logic [TM_DW-1:0] b_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_adr   <= '0;
      m_wen   <= 1'b0;
      m_wrt   <= '0;
      last_b  <= 1'b1;
      tag_vld <= 1'b0;
      tag_b   <= 1'b0;
      a_rvl   <= 1'b0;
      b_rvl   <= 1'b0;
      a_hold  <= '0;
      b_hold  <= '0;
    end else begin
      tag_vld <= (a_gnt && !a_wen) || (b_gnt && !b_wen);
      tag_b   <= b_gnt;
      a_rvl   <= tag_vld && !tag_b;
      b_rvl   <= tag_vld && tag_b;
      if (a_rvl) a_hold <= m_red;
      if (b_rvl) b_hold <= m_red;

      if (fill_act) begin
        m_adr <= fill_cnt;
        m_wen <= 1'b1;
        m_wrt <= fill_val;
      end else if (a_gnt) begin
        m_adr  <= a_adr;
        m_wen  <= a_wen;
        m_wrt  <= a_wrt;
        last_b <= 1'b0;
      end else if (b_gnt) begin
        m_adr  <= b_adr;
        m_wen  <= b_wen;
        m_wrt  <= b_wrt;
        last_b <= 1'b1;
      end else begin
        m_wen <= 1'b0;
      end
    end
  end

  // m_red carries the data in the pulse cycle itself; the hold registers keep
  // the last value between pulses.
  assign a_rdt = a_rvl ? m_red : a_hold;
  assign b_rdt = b_rvl ? m_red : b_hold;

endmodule

// File: tb/tb_fpga_robots_tm_arbiter.sv
module tb_fpga_robots_tm_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 1'b0, b_req = 1'b0;
  logic [12:0] a_adr = '0, b_adr = '0;
  logic        a_wen = 1'b0, b_wen = 1'b0;
  logic [7:0]  a_wrt = '0, b_wrt = '0;
  logic        a_gnt, b_gnt, a_rvl, b_rvl;
  logic [7:0]  a_rdt, b_rdt;
  logic        clr_stb = 1'b0;
  logic [7:0]  clr_val = '0;
  logic        clr_busy;
  logic [12:0] m_adr;
  logic        m_wen;
  logic [7:0]  m_wrt;
  logic [7:0]  m_red = '0;

  int total = 0;
  int bad = 0;
  logic [8:0] exp_q[$];  // {port_b, data} of each expected read return

  fpga_robots_tm_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_adr(a_adr), .a_wen(a_wen), .a_wrt(a_wrt),
    .a_gnt(a_gnt), .a_rvl(a_rvl), .a_rdt(a_rdt),
    .b_req(b_req), .b_adr(b_adr), .b_wen(b_wen), .b_wrt(b_wrt),
    .b_gnt(b_gnt), .b_rvl(b_rvl), .b_rdt(b_rdt),
    .clr_stb(clr_stb), .clr_val(clr_val), .clr_busy(clr_busy),
    .m_adr(m_adr), .m_wen(m_wen), .m_wrt(m_wrt), .m_red(m_red)
  );

  // clock / reset
  always #5 clk = ~clk;

  // tile map memory model: registered read, read-before-write
  logic [7:0] mem [0:8191];

  function automatic logic [7:0] pat(input logic [12:0] a);
    return a[7:0] ^ 8'h3C ^ {3'b000, a[12:8]};
  endfunction

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = pat(13'(i));
  end

  always @(posedge clk) begin
    m_red <= mem[m_adr];
    if (m_wen) mem[m_adr] <= m_wrt;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard: every read return is matched against the expected queue
  always @(negedge clk) begin
    if (!rst && (a_rvl || b_rvl)) begin
      if (exp_q.size() == 0) begin
        chk("rvl_unexpected", {a_rvl, b_rvl}, 0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if (a_rvl) chk("rdt_data", {1'b0, a_rdt}, e);
        else       chk("rdt_data", {1'b1, b_rdt}, e);
      end
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_req = 1'b0; b_req = 1'b0; clr_stb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic drive_a(input logic req, input logic [12:0] adr, input logic wen, input logic [7:0] wrt);
    a_req = req; a_adr = adr; a_wen = wen; a_wrt = wrt;
  endtask

  task automatic drive_b(input logic req, input logic [12:0] adr, input logic wen, input logic [7:0] wrt);
    b_req = req; b_adr = adr; b_wen = wen; b_wrt = wrt;
  endtask

  typedef struct {
    logic        a_req;
    logic [12:0] a_adr;
    logic        b_req;
    logic [12:0] b_adr;
    logic        exp_a;
    logic        exp_b;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // round-robin reads, starting from reset (last grant = B)
    vecs[0] = '{1'b1, 13'h020, 1'b0, 13'h000, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 13'h021, 1'b1, 13'h040, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 13'h021, 1'b1, 13'h041, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 13'h000, 1'b1, 13'h041, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 13'h022, 1'b1, 13'h042, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 13'h000, 1'b1, 13'h042, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 13'h000, 1'b0, 13'h000, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 13'h023, 1'b1, 13'h043, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 13'h024, 1'b1, 13'h043, 1'b0, 1'b1};
    vecs[9] = '{1'b1, 13'h024, 1'b0, 13'h000, 1'b1, 1'b0};

    do_reset();

    // reset state
    @(negedge clk);
    chk("rst_m_adr", m_adr, 0);
    chk("rst_m_wen", m_wen, 0);
    chk("rst_m_wrt", m_wrt, 0);
    chk("rst_rvl", {a_rvl, b_rvl}, 0);
    chk("rst_rdt", {a_rdt, b_rdt}, 0);
    chk("rst_busy", clr_busy, 0);

    // single A read of 0x0010
    next_cycle();
    drive_a(1'b1, 13'h0010, 1'b0, 8'h00);
    @(negedge clk);
    chk("t1_a_gnt", a_gnt, 1);
    chk("t1_b_gnt", b_gnt, 0);
    exp_q.push_back({1'b0, pat(13'h0010)});
    next_cycle();
    drive_a(1'b0, 13'h0000, 1'b0, 8'h00);
    @(negedge clk);
    chk("t1_m_adr", m_adr, 13'h0010);
    chk("t1_m_wen", m_wen, 0);
    chk("t1_rvl_early", a_rvl, 0);
    next_cycle();
    @(negedge clk);
    chk("t1_a_rvl", a_rvl, 1);
    chk("t1_a_rdt", a_rdt, pat(13'h0010));
    chk("t1_b_rvl", b_rvl, 0);
    next_cycle();
    @(negedge clk);
    chk("t1_rvl_pulse", a_rvl, 0);
    chk("t1_rdt_hold", a_rdt, pat(13'h0010));

    // arbitration table
    do_reset();
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      drive_a(vecs[i].a_req, vecs[i].a_adr, 1'b0, 8'h00);
      drive_b(vecs[i].b_req, vecs[i].b_adr, 1'b0, 8'h00);
      @(negedge clk);
      chk($sformatf("vec%0d_a_gnt", i), a_gnt, vecs[i].exp_a);
      chk($sformatf("vec%0d_b_gnt", i), b_gnt, vecs[i].exp_b);
      if (vecs[i].exp_a) exp_q.push_back({1'b0, pat(vecs[i].a_adr)});
      if (vecs[i].exp_b) exp_q.push_back({1'b1, pat(vecs[i].b_adr)});
    end
    next_cycle();
    drive_a(1'b0, 13'h0, 1'b0, 8'h0);
    drive_b(1'b0, 13'h0, 1'b0, 8'h0);
    repeat (3) next_cycle();
    chk("vec_q_empty", exp_q.size(), 0);

    // continuous dual requests: A writes 0x0001, B reads 0x0002
    do_reset();
    begin
      logic [7:0] bg;
      bg = '0;
      for (int k = 0; k < 8; k++) begin
        next_cycle();
        drive_a(k < 6, 13'h0001, 1'b1, 8'h11);
        drive_b(k < 6, 13'h0002, 1'b0, 8'h00);
        @(negedge clk);
        chk($sformatf("alt%0d_a_gnt", k), a_gnt, (k < 6) && (k % 2 == 0));
        chk($sformatf("alt%0d_b_gnt", k), b_gnt, (k < 6) && (k % 2 == 1));
        if (k >= 2) chk($sformatf("alt%0d_b_rvl", k), b_rvl, bg[k-2]);
        chk($sformatf("alt%0d_a_rvl", k), a_rvl, 0);
        if ((k < 6) && (k % 2 == 1)) begin
          bg[k] = 1'b1;
          exp_q.push_back({1'b1, pat(13'h0002)});
        end
      end
    end
    repeat (2) next_cycle();

    // B writes 0x55 to 0x1FFF, A reads it back on the next cycle
    next_cycle();
    drive_b(1'b1, 13'h1FFF, 1'b1, 8'h55);
    @(negedge clk);
    chk("wr_b_gnt", b_gnt, 1);
    next_cycle();
    drive_b(1'b0, 13'h0, 1'b0, 8'h0);
    drive_a(1'b1, 13'h1FFF, 1'b0, 8'h0);
    @(negedge clk);
    chk("rd_a_gnt", a_gnt, 1);
    exp_q.push_back({1'b0, 8'h55});
    next_cycle();
    drive_a(1'b0, 13'h0, 1'b0, 8'h0);
    next_cycle();
    @(negedge clk);
    chk("rd_a_rvl", a_rvl, 1);
    chk("rd_a_rdt", a_rdt, 8'h55);
    next_cycle();

`ifdef FPGA_ROBOTS_TMARB_CLEAR_EN
    // full fill with A read pending throughout
    next_cycle();
    clr_stb = 1'b1;
    clr_val = 8'h20;
    drive_a(1'b1, 13'h0003, 1'b0, 8'h0);
    @(negedge clk);
    chk("fill_stb_a_gnt", a_gnt, 0);
    begin
      int err_busy, err_gnt, err_adr;
      err_busy = 0; err_gnt = 0; err_adr = 0;
      for (int k = 0; k < 8192; k++) begin
        next_cycle();
        clr_stb = 1'b0;
        @(negedge clk);
        if (clr_busy !== 1'b1) err_busy++;
        if (a_gnt !== 1'b0 || b_gnt !== 1'b0) err_gnt++;
        if (k >= 1 && (m_adr !== 13'(k - 1) || m_wen !== 1'b1 || m_wrt !== 8'h20)) err_adr++;
      end
      chk("fill_busy_errs", err_busy, 0);
      chk("fill_gnt_errs", err_gnt, 0);
      chk("fill_adr_errs", err_adr, 0);
    end
    next_cycle();
    @(negedge clk);
    chk("fill_busy_fall", clr_busy, 0);
    chk("fill_last_adr", m_adr, 13'h1FFF);
    chk("fill_last_wen", m_wen, 1);
    chk("fill_after_a_gnt", a_gnt, 1);
    exp_q.push_back({1'b0, 8'h20});
    next_cycle();
    drive_a(1'b0, 13'h0, 1'b0, 8'h0);
    repeat (2) next_cycle();
`endif

    // clr_stb and a_req together, one cycle after a granted A read
    next_cycle();
    drive_a(1'b1, 13'h0004, 1'b0, 8'h0);
    @(negedge clk);
    chk("stb_prior_a_gnt", a_gnt, 1);
`ifdef FPGA_ROBOTS_TMARB_CLEAR_EN
    exp_q.push_back({1'b0, 8'h20});
`else
    exp_q.push_back({1'b0, pat(13'h0004)});
`endif
    next_cycle();
    clr_stb = 1'b1;
    clr_val = 8'h77;
    drive_a(1'b1, 13'h0005, 1'b0, 8'h0);
    @(negedge clk);
`ifdef FPGA_ROBOTS_TMARB_CLEAR_EN
    chk("stb_same_a_gnt", a_gnt, 0);
`else
    chk("stb_same_a_gnt", a_gnt, 1);
    exp_q.push_back({1'b0, pat(13'h0005)});
`endif
    next_cycle();
    clr_stb = 1'b0;
    drive_a(1'b0, 13'h0, 1'b0, 8'h0);
    @(negedge clk);
    chk("stb_prior_a_rvl", a_rvl, 1);
`ifdef FPGA_ROBOTS_TMARB_CLEAR_EN
    chk("stb_busy", clr_busy, 1);
    begin
      bit found;
      found = 1'b0;
      for (int k = 0; k < 600 && !found; k++) begin
        if (m_adr == 13'h0100 && m_wen) found = 1'b1;
        else begin
          next_cycle();
          @(negedge clk);
        end
      end
      chk("mid_fill_reached", found, 1);
    end
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", clr_busy, 0);
    chk("mid_rst_m_wen", m_wen, 0);
    chk("mid_rst_m_adr", m_adr, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    chk("post_rst_busy", clr_busy, 0);
`else
    chk("stb_busy", clr_busy, 0);
    next_cycle();
    @(negedge clk);
    chk("stb_noeffect_m_adr", m_adr, 13'h0005);
    chk("stb_noeffect_m_wen", m_wen, 0);
    chk("stb_noeffect_busy", clr_busy, 0);
    repeat (2) next_cycle();
`endif

    chk("final_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
